cmos_serial_tx: RTL and testbench
=================================

CMOS_SERIAL_TX -- requirements
Module: cmos_serial_tx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 4, giving the clock cycles per serial bit (legal values 2..255).
REQ-002 The module SHALL have parameter PARITY_EN, default 0; when set to 1, an even-parity bit is inserted after the data bits.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port tx_data, input, 8 bits: byte to send, sampled on acceptance.
REQ-006 Port tx_valid, input, 1 bit: the source offers tx_data.
REQ-007 Port tx_ready, output, 1 bit: the block can accept a byte.
REQ-008 Port tx_busy, output, 1 bit: a frame is in progress.
REQ-009 Port pad, output (tri), 1 bit: serial line, driven only by the switch-level CMOS output stage; high-Z when not transmitting.

Function
REQ-010 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP; the encoding is a shared constant.
REQ-011 In IDLE: tx_ready=1, tx_busy=0, pad=Z.
REQ-012 A byte SHALL be accepted on a rising edge with tx_valid&&tx_ready; tx_data is latched into the shift register and the FSM moves to START.
REQ-013 tx_ready SHALL be 0 in every state other than IDLE; tx_valid asserted while not ready is ignored, and tx_data changes after acceptance have no effect.
REQ-014 Latency: pad SHALL be driven 0 starting at the first clock edge after the accepting edge.
REQ-015 Each bit SHALL occupy exactly CLKS_PER_BIT cycles, timed by a down-counter that reloads at every bit boundary.
REQ-016 START drives 0. DATA drives the 8 bits LSB first, with a 3-bit index that does not wrap (the exit at index 7 goes to PARITY or STOP). PARITY drives the XOR of the 8 bits. STOP drives 1.
REQ-017 The FSM SHALL leave STOP for IDLE after its last cycle, so there is a minimum of 1 IDLE cycle between frames; a held tx_valid is accepted in that IDLE cycle.
REQ-018 Frame length SHALL be (10+PARITY_EN)*CLKS_PER_BIT cycles, with tx_busy=1 for exactly that many cycles.
REQ-019 The output stage SHALL be controlled by registered gates pg (to pmos) and ng (to nmos):
- drive 1: pg=0, ng=0
- drive 0: pg=1, ng=1
- Z: pg=1, ng=0
REQ-020 The combination pg=0 with ng=1 (crowbar) SHALL never occur, including on any cycle and across any transition.

Reset
REQ-021 While rst_n=0, the block SHALL hold state=IDLE, pg=1, ng=0 (pad=Z), tx_ready=0, tx_busy=0, and counter, bit index and shift register all at 0.
REQ-022 Reset assertion SHALL take effect immediately without waiting for clk; a frame in progress is discarded and no partial bits resume.
REQ-023 After deassertion, tx_ready SHALL become 1 on the first rising clk edge.

Structure
REQ-024 Package cmos_tx_pkg SHALL hold the state encoding, the gate-control constants (DRIVE1/DRIVE0/HIZ pg,ng pairs) and the frame-length function.
REQ-025 One sub-module, cmos_tristate_driver, SHALL form the output stage:
- inputs pg and ng; output pad
- built from supply1/supply0 with one pmos and one nmos switch-level primitive
- no logic
REQ-026 All sequencing SHALL reside in cmos_serial_tx; the register/FSM part is behavioural RTL.

Verification
REQ-027 The bench SHALL place a pullup on pad and check for X/Z-free values while the line is driven.
REQ-028 Scenario: CLKS_PER_BIT=4, PARITY_EN=0, send 0xA5 -> pad shows 0,1,0,1,0,0,1,0,1,1, each for 4 cycles; tx_busy lasts 40 cycles; pad is Z afterwards.
REQ-029 Scenario: PARITY_EN=1, send 0x07 -> parity bit=1 (three ones); frame is 44 cycles.
REQ-030 Scenario: tx_valid held high with 0x55 then 0xAA -> the second byte is accepted exactly 1 IDLE cycle after the first STOP ends; no pad glitch to Z inside either frame.
REQ-031 Scenario: rst_n pulled low mid-DATA (cycle 17 of a frame), between clock edges -> pad=Z and tx_busy=0 immediately; after release, tx_ready=1 at the first edge and the next frame is correct.
REQ-032 Scenario: tx_valid pulses during busy with 0xFF -> ignored; the only frame sent is the original byte.
REQ-033 An assertion SHALL check !(pg==0 && ng==1) on every cycle of all scenarios.

Source files
------------

// File: rtl/cmos_tx_pkg.sv
// Shared definitions for the CMOS serial transmitter: FSM encoding, output-stage
// gate pairs and the frame-length helper.
package cmos_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // pg drives the pmos gate, ng drives the nmos gate; pg=0 with ng=1 is a crowbar.
  typedef struct packed {
    logic pg;
    logic ng;
  } gate_t;

  localparam gate_t DRIVE1 = '{pg: 1'b0, ng: 1'b0};
  localparam gate_t DRIVE0 = '{pg: 1'b1, ng: 1'b1};
  localparam gate_t HIZ    = '{pg: 1'b1, ng: 1'b0};

  function automatic int frame_cycles(input int clks_per_bit, input int parity_en);
    return (10 + parity_en) * clks_per_bit;
  endfunction

endpackage

// File: rtl/cmos_tristate_driver.sv
// Switch-level CMOS output stage: one pmos pull-up and one nmos pull-down.
module cmos_tristate_driver (
  input  logic pg,
  input  logic ng,
  output tri   pad
);

  supply1 vdd;
  supply0 gnd;

  pmos p_up (pad, vdd, pg);
  nmos n_dn (pad, gnd, ng);

endmodule

// File: rtl/cmos_serial_tx.sv
// Byte-wide serial transmitter with optional even parity, driving a tri-state
// pad through registered CMOS gate controls.
module cmos_serial_tx
  import cmos_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output tri         pad
);

  localparam logic [7:0] RELOAD = 8'(CLKS_PER_BIT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift_reg;
  logic       parity_bit;
  logic       pg;
  logic       ng;
  logic       bit_done;

  assign bit_done = (cnt == 8'd0);

  // Gates and tx_busy are registered from the current state, so the pad trails
  // the FSM by one cycle and both gate bits always change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      bit_idx    <= 3'd0;
      shift_reg  <= 8'd0;
      parity_bit <= 1'b0;
      {pg, ng}   <= HIZ;
      tx_ready   <= 1'b0;
      tx_busy    <= 1'b0;
    end else begin
      tx_busy <= (state != IDLE);

      case (state)
        IDLE:    {pg, ng} <= HIZ;
        START:   {pg, ng} <= DRIVE0;
        DATA:    {pg, ng} <= shift_reg[0] ? DRIVE1 : DRIVE0;
        PARITY:  {pg, ng} <= parity_bit ? DRIVE1 : DRIVE0;
        STOP:    {pg, ng} <= DRIVE1;
        default: {pg, ng} <= HIZ;
      endcase

      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shift_reg  <= tx_data;
            parity_bit <= ^tx_data;
            cnt        <= RELOAD;
            bit_idx    <= 3'd0;
            tx_ready   <= 1'b0;
            state      <= START;
          end else begin
            tx_ready <= 1'b1;
          end
        end
        START: begin
          if (bit_done) begin
            cnt   <= RELOAD;
            state <= DATA;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            cnt       <= RELOAD;
            shift_reg <= {1'b0, shift_reg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        PARITY: begin
          if (bit_done) begin
            cnt   <= RELOAD;
            state <= STOP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        STOP: begin
          // Counter lands at zero here, so IDLE starts with a clean counter.
          if (bit_done) begin
            tx_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  cmos_tristate_driver u_drv (
    .pg  (pg),
    .ng  (ng),
    .pad (pad)
  );

endmodule

// File: tb/tb_cmos_serial_tx.sv
// Scoreboard bench for cmos_serial_tx: two instances (no parity / even parity),
// stimulus pushes expected frames, per-instance monitors decode the pad.
module tb_cmos_serial_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] tx_data0 = 8'h00;
  logic [7:0] tx_data1 = 8'h00;
  logic       tx_valid0 = 1'b0;
  logic       tx_valid1 = 1'b0;
  wire        tx_ready0, tx_busy0, tx_ready1, tx_busy1;
  tri         pad0, pad1;

  pullup (pad0);
  pullup (pad1);

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [10:0] bits;
    int          gap;
    bit          abort;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  cmos_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0)) dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data0),
    .tx_valid (tx_valid0),
    .tx_ready (tx_ready0),
    .tx_busy  (tx_busy0),
    .pad      (pad0)
  );

  cmos_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data1),
    .tx_valid (tx_valid1),
    .tx_ready (tx_ready1),
    .tx_busy  (tx_busy1),
    .pad      (pad1)
  );

  always #5 clk = ~clk;

  logic [1:0] busy_v, ready_v, pad_v, hiz_v;
  assign busy_v  = {tx_busy1, tx_busy0};
  assign ready_v = {tx_ready1, tx_ready0};
  assign pad_v   = {pad1, pad0};
  assign hiz_v   = {dut1.pg & ~dut1.ng, dut0.pg & ~dut0.ng};

  // The output stage must never see pmos and nmos on together.
  always @(posedge clk or negedge clk) begin
    if (!$isunknown({dut0.pg, dut0.ng, dut1.pg, dut1.ng})) begin
      assert (!(dut0.pg == 1'b0 && dut0.ng == 1'b1) && !(dut1.pg == 1'b0 && dut1.ng == 1'b1))
      else begin
        miscompares++;
        $display("[TB] FAIL crowbar: dut0 pg/ng=%b%b dut1 pg/ng=%b%b required not 01",
                 dut0.pg, dut0.ng, dut1.pg, dut1.ng);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
    end
  endtask

  task automatic popExpected(input int sel, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '{bits: 11'd0, gap: -1, abort: 1'b0};
    if (sel == 0) begin
      if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
    end else begin
      if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
    end
  endtask

  function automatic int queueSize(input int sel);
    return (sel == 0) ? q0.size() : q1.size();
  endfunction

  // Decodes one instance's pad cycle by cycle and checks each frame on busy fall.
  task automatic monitor(input int sel);
    int   nb, len, idle, gap, zcnt;
    bit   in_frame, ok;
    logic samp[64];
    logic [3:0] got;
    exp_t e;
    nb = 10 + sel;
    in_frame = 1'b0;
    idle = 1000;
    len = 0; gap = 0; zcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        if (in_frame) begin
          popExpected(sel, e, ok);
          if (!ok) checkOutput($sformatf("dut%0d_unexpected_aborted_frame", sel), 1, 0);
          else     checkOutput($sformatf("dut%0d_frame_aborted", sel), 32'(e.abort), 1);
        end
        in_frame = 1'b0;
        idle = 1000;
      end else if (busy_v[sel]) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          len = 0; zcnt = 0; gap = idle;
          for (int i = 0; i < 64; i++) samp[i] = 1'bx;
        end
        if (len < 64) samp[len] = pad_v[sel];
        if (hiz_v[sel]) zcnt++;
        len++;
      end else begin
        if (in_frame) begin
          in_frame = 1'b0;
          popExpected(sel, e, ok);
          if (!ok) begin
            checkOutput($sformatf("dut%0d_unexpected_frame", sel), 1, 0);
          end else begin
            checkOutput($sformatf("dut%0d_frame_len", sel), len, nb * 4);
            for (int k = 0; k < nb; k++) begin
              for (int j = 0; j < 4; j++) got[j] = samp[4 * k + j];
              checkOutput($sformatf("dut%0d_bit%0d", sel, k), 32'(got), {28'd0, {4{e.bits[nb - 1 - k]}}});
            end
            checkOutput($sformatf("dut%0d_no_z_in_frame", sel), zcnt, 0);
            checkOutput($sformatf("dut%0d_not_aborted", sel), 32'(e.abort), 0);
            if (e.gap >= 0) checkOutput($sformatf("dut%0d_idle_gap", sel), gap, e.gap);
          end
          idle = 0;
        end
        idle++;
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic driveIn(input int sel, input logic [7:0] d, input logic v);
    if (sel == 0) begin tx_data0 = d; tx_valid0 = v; end
    else          begin tx_data1 = d; tx_valid1 = v; end
  endtask

  // Pushes the expected frame, then offers the byte for exactly one accepting edge.
  task automatic applyStimulus(input int sel, input logic [7:0] d, input logic [10:0] bits,
                               input int gap, input bit abort);
    exp_t e;
    bit   done;
    e = '{bits: bits, gap: gap, abort: abort};
    if (sel == 0) q0.push_back(e); else q1.push_back(e);
    done = 1'b0;
    for (int n = 0; n < 500 && !done; n++) begin
      @(negedge clk);
      if (ready_v[sel]) begin
        driveIn(sel, d, 1'b1);
        @(negedge clk);
        driveIn(sel, ~d, 1'b0);
        done = 1'b1;
      end
    end
    if (!done) checkOutput($sformatf("dut%0d_accept_timeout", sel), 1, 0);
  endtask

  task automatic waitDone(input int sel);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 2000 && !done; n++) begin
      @(negedge clk);
      if (queueSize(sel) == 0 && !busy_v[sel] && ready_v[sel]) done = 1'b1;
    end
    if (!done) checkOutput($sformatf("dut%0d_done_timeout", sel), 1, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation time exceeded");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit seen;

    #2 rst_n = 1'b0;
    #3;
    checkOutput("reset_ready", tx_ready0, 0);
    checkOutput("reset_busy", tx_busy0, 0);
    checkOutput("reset_pad_z", hiz_v[0], 1);
    checkOutput("reset_pad_z_p", hiz_v[1], 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("ready_first_edge", tx_ready0, 1);

    // 0xA5, no parity: 0,1,0,1,0,0,1,0,1,1
    applyStimulus(0, 8'hA5, 11'b0101001011, -1, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("ready_while_busy", tx_ready0, 0);
    checkOutput("busy_mid_frame", tx_busy0, 1);
    waitDone(0);
    checkOutput("pad_z_after", hiz_v[0], 1);
    checkOutput("pad_pulled_high", pad0, 1);

    // Parity instance: 0x07 -> parity 1; 0x00 -> parity 0
    applyStimulus(1, 8'h07, 11'b01110000011, -1, 1'b0);
    applyStimulus(1, 8'h00, 11'b00000000001, -1, 1'b0);
    waitDone(1);

    // Held tx_valid: 0x55 then 0xAA, one idle cycle between frames
    q0.push_back('{bits: 11'b0101010101, gap: -1, abort: 1'b0});
    q0.push_back('{bits: 11'b0010101011, gap: 1, abort: 1'b0});
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (tx_ready0) seen = 1'b1;
    end
    tx_data0 = 8'h55; tx_valid0 = 1'b1;
    @(negedge clk);
    tx_data0 = 8'hAA;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (tx_ready0) seen = 1'b1;
    end
    if (!seen) checkOutput("held_valid_timeout", 1, 0);
    @(negedge clk);
    tx_valid0 = 1'b0;
    waitDone(0);

    // 0x0F with 0xFF pulses during busy that must be ignored
    applyStimulus(0, 8'h0F, 11'b0111100001, -1, 1'b0);
    for (int p = 0; p < 3; p++) begin
      repeat ((p == 0) ? 4 : 10) @(negedge clk);
      checkOutput($sformatf("ready_low_pulse%0d", p), tx_ready0, 0);
      driveIn(0, 8'hFF, 1'b1);
      @(negedge clk);
      driveIn(0, 8'hFF, 1'b0);
    end
    waitDone(0);

    // Reset during DATA at busy cycle 17, between edges
    applyStimulus(0, 8'hC3, 11'b0, -1, 1'b1);
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(posedge clk);
      #1;
      if (tx_busy0) seen = 1'b1;
    end
    repeat (16) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy_low", tx_busy0, 0);
    checkOutput("abort_pad_z", hiz_v[0], 1);
    checkOutput("abort_ready_low", tx_ready0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("ready_after_release", tx_ready0, 1);
    // 0x3C after reset: 0,0,0,1,1,1,1,0,0,1
    applyStimulus(0, 8'h3C, 11'b0001111001, -1, 1'b0);
    waitDone(0);

    repeat (60) @(negedge clk);
    checkOutput("q0_empty", q0.size(), 0);
    checkOutput("q1_empty", q1.size(), 0);
    checkOutput("final_pad_z", hiz_v[0], 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
